// File: rtl/fir_out_requant.sv
// fir_out_requant: rounds/shifts/saturates 32-bit FIR results to 16 bits into a FWFT FIFO; define FIR_REQUANT_SAT_CNT_EN to build sat_count
module fir_out_requant #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  yn,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic [15:0]      sat_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] HI  = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] LO  = ~HI;
    logic signed [IN_W:0] sum, s1_r;
    logic s1_v, s2_v, accept, pop;
    logic [OUT_W-1:0] s2_d, clamp_d;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [AW+1:0] credit;

    assign sum       = $signed({yn[IN_W-1], yn}) + RND;
    assign clamp_d   = s1_r > HI ? HI[OUT_W-1:0] : s1_r < LO ? LO[OUT_W-1:0] : s1_r[OUT_W-1:0];
    assign credit    = (AW+2)'(count) + (AW+2)'(s1_v) + (AW+2)'(s2_v);
    assign in_ready  = credit < (AW+2)'(DEPTH);
    assign accept    = in_valid && in_ready;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // round/shift stage, clamp stage and FIFO bookkeeping; space for in-flight samples is reserved by the credit check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s1_r   <= '0;
            s2_d   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            s1_v   <= accept;
            s1_r   <= sum >>> SHIFT;
            s2_v   <= s1_v;
            s2_d   <= clamp_d;
            wr_ptr <= s2_v ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(s2_v) - (AW+1)'(pop);
        end
    end

    // FIFO storage is not reset; only occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (s2_v) mem[wr_ptr] <= s2_d;
    end

`ifdef FIR_REQUANT_SAT_CNT_EN
    logic s2_sat;

    // track the clamp flag alongside s2 and count saturated writes, sticking at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_sat    <= 1'b0;
            sat_count <= '0;
        end else begin
            s2_sat    <= (s1_r > HI) || (s1_r < LO);
            sat_count <= s2_v && s2_sat && sat_count != '1 ? sat_count + 16'd1 : sat_count;
        end
    end
`else
    assign sat_count = '0;
`endif
endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed and random checks of fir_out_requant against a queue-based occupancy model
module tb_fir_out_requant;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] yn = '0;
    logic in_ready, out_valid;
    logic [15:0] out_data, sat_count;
    int errors = 0, checks = 0;
    bit acc;
    typedef struct { logic [15:0] d; bit s; int age; } ent_t;
    ent_t pipe[$];
    logic [15:0] fq[$];
    logic [15:0] acc_log[$];
    int got[$];
    logic [15:0] esat = '0;

    fir_out_requant dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .yn(yn), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] rq(input logic [31:0] y);
        longint v = longint'($signed(y)) + 128;
        longint q = v / 256;
        if (v < 0 && v % 256 != 0) q = q - 1;
        if (q > 32767) return {1'b1, 16'h7fff};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] g(input int i);
        return i < got.size() ? 32'(got[i]) : 32'hxxxxxxxx;
    endfunction

    task automatic tick();
        bit er, ev, pop;
        logic [15:0] ed;
        logic [16:0] r;
        er = (fq.size() + pipe.size()) < 4;
        ev = fq.size() != 0;
        ed = ev ? fq[0] : 16'h0;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_data", 32'(out_data), 32'(ed));
        chk("sat_count", 32'(sat_count), 32'(esat));
        acc = in_valid && er;
        pop = ev && out_ready;
        r = rq(yn);
        if (pop) got.push_back(int'(out_data));
        @(posedge clk);
        if (pop) void'(fq.pop_front());
        for (int i = 0; i < pipe.size(); i++) pipe[i].age++;
        if (pipe.size() != 0 && pipe[0].age == 2) begin
            fq.push_back(pipe[0].d);
`ifdef FIR_REQUANT_SAT_CNT_EN
            if (pipe[0].s && esat != 16'hffff) esat++;
`endif
            void'(pipe.pop_front());
        end
        if (acc) begin
            pipe.push_back('{r[15:0], r[16], 0});
            acc_log.push_back(r[15:0]);
        end
        @(negedge clk);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_sat_count"}, 32'(sat_count), 32'd0);
    endtask

    task automatic clear_model();
        fq.delete();
        pipe.delete();
        acc_log.delete();
        got.delete();
        esat = '0;
    endtask

    task automatic order_chk(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(acc_log.size()));
        for (int i = 0; i < acc_log.size(); i++) chk($sformatf("%s%0d", tag, i), g(i), 32'(acc_log[i]));
    endtask

    function automatic logic [31:0] rnd_yn();
        int unsigned k = $urandom_range(0, 3);
        return k == 0 ? $urandom() :
               k == 1 ? 32'($signed(24'($urandom()))) :
               k == 2 ? (32'($signed(20'($urandom()))) & 32'hffffff00) | 32'h80 :
                        32'($signed(16'($urandom())));
    endfunction

    initial begin
        int k;
        int rv[4];
        #1 rst_chk("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        out_ready = 1'b1;
        in_valid = 1'b1;
        yn = 32'd25600;
        tick();
        in_valid = 1'b0;
        tick();
        chk("single_early", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'd100);
        chk("single_sat", 32'(sat_count), 32'd0);
        tick();
        tick();

        got.delete();
        rv = '{384, -384, 127, 128};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            yn = 32'(rv[i]);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("round0", g(0), 32'h0002);
        chk("round1", g(1), 32'hffff);
        chk("round2", g(2), 32'h0000);
        chk("round3", g(3), 32'h0001);

        got.delete();
        in_valid = 1'b1;
        yn = 32'h7fffffff;
        tick();
        yn = 32'h80000000;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_hi", g(0), 32'h7fff);
        chk("sat_lo", g(1), 32'h8000);
`ifdef FIR_REQUANT_SAT_CNT_EN
        chk("sat_cnt", 32'(sat_count), 32'd2);
`else
        chk("sat_cnt", 32'(sat_count), 32'd0);
`endif

        got.delete();
        out_ready = 1'b0;
        k = 1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            yn = 32'(256 * k);
            tick();
            if (acc) k++;
        end
        chk("bp_accepts", 32'(k), 32'd5);
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        if (acc) k++;
        chk("bp_reready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 12; c++) begin
            in_valid = k <= 6;
            yn = 32'(256 * k);
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("bp_total", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("bp_out%0d", i), g(i), 32'(i + 1));

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            yn = 32'(256 * (i + 10));
            tick();
        end
        in_valid = 1'b0;
        chk("mr_buffered", 32'(out_valid), 32'd1);
        chk("mr_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1 rst_chk("mid_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        out_ready = 1'b1;
        in_valid = 1'b1;
        yn = 32'd512;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mr_first", g(0), 32'd2);
        chk("mr_count", 32'(got.size()), 32'd1);

        clear_model();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            yn = rnd_yn();
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            yn = rnd_yn();
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        order_chk("wrap");

        clear_model();
        for (int c = 0; c < 300; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            yn = rnd_yn();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        chk("rand_drained", 32'(out_valid), 32'd0);
        order_chk("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
